matmul_sequencer: RTL and testbench

Sequencer for the N×N matrix-multiply datapath. On a start pulse it walks all (i, j, k) index triples and drives three things: operand reads (A[i][k], B[k][j]), multiply-accumulate strobes to the shared MAC, and result writes (C[i][j]). It sits between the top-level control (start/done) and the operand memories plus MAC unit. A hold input lets upstream logic insert bubbles without losing position.

---
 rtl/matmul_sequencer.sv | 137 +++++++++++++
 tb/tb_matmul_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Index sequencer for an NxN matrix multiply: walks (i, j, k) with k innermost,
// issues operand reads, drives MAC strobes one cycle later and C writes two cycles later.
module matmul_sequencer #(
  parameter int N  = 4,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          hold,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_en,
  output logic          mac_first,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          done
);

  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [AW-1:0] N_A  = AW'(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] i_q, j_q, k_q;
  logic [IW-1:0] i_nxt, j_nxt, k_nxt;
  logic          flush_q, flush_nxt;

  logic          v1, first1, last1;
  logic [AW-1:0] idx1;

  assign a_addr    = AW'(i_q) * N_A + AW'(k_q);
  assign b_addr    = AW'(k_q) * N_A + AW'(j_q);
  assign mac_en    = v1;
  assign mac_first = v1 & first1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt = state;
    i_nxt     = i_q;
    j_nxt     = j_q;
    k_nxt     = k_q;
    flush_nxt = flush_q;
    rd_en     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end

      RUN: begin
        busy  = 1'b1;
        rd_en = ~hold;
        // Odometer advance with k innermost; a held cycle freezes position.
        if (!hold) begin
          if (k_q != LAST) begin
            k_nxt = k_q + IW'(1);
          end else begin
            k_nxt = '0;
            if (j_q != LAST) begin
              j_nxt = j_q + IW'(1);
            end else begin
              j_nxt = '0;
              if (i_q != LAST) begin
                i_nxt = i_q + IW'(1);
              end else begin
                i_nxt     = '0;
                state_nxt = FLUSH;
              end
            end
          end
        end
      end

      FLUSH: begin
        busy      = 1'b1;
        flush_nxt = ~flush_q;
        if (flush_q) state_nxt = DONE;
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset) begin
      state   <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      i_q     <= i_nxt;
      j_q     <= j_nxt;
      k_q     <= k_nxt;
      flush_q <= flush_nxt;
    end
  end

  // Two-stage tag pipeline: stage 1 tags the MAC input, stage 2 the C write.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
      idx1   <= '0;
      c_we   <= 1'b0;
      c_addr <= '0;
    end else begin
      v1     <= rd_en;
      first1 <= (k_q == '0);
      last1  <= (k_q == LAST);
      idx1   <= AW'(i_q) * N_A + AW'(j_q);
      c_we   <= v1 & last1;
      if (v1 & last1) c_addr <= idx1;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: per-cycle comparison against an event
// timeline built from the index-walk rules, plus a MAC/memory model that checks C = A*B.
module tb_matmul_sequencer;

  localparam int N    = 4;
  localparam int AW   = 4;
  localparam int NN   = N * N;
  localparam int NNN  = N * N * N;
  localparam int MAXC = 256;

  logic          clock = 1'b0;
  logic          reset, start, hold;
  logic          rd_en, mac_en, mac_first, c_we, busy, done;
  logic [AW-1:0] a_addr, b_addr, c_addr;

  logic          reset2, start2, hold2;
  logic          rd_en2, mac_en2, mac_first2, c_we2, busy2, done2;
  logic [1:0]    a_addr2, b_addr2, c_addr2;

  always #5 clock = ~clock;

  matmul_sequencer #(.N(N), .AW(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .mac_en(mac_en), .mac_first(mac_first), .c_we(c_we), .c_addr(c_addr),
    .busy(busy), .done(done)
  );

  matmul_sequencer #(.N(2), .AW(2)) dut2 (
    .clock(clock), .reset(reset2), .start(start2), .hold(hold2),
    .rd_en(rd_en2), .a_addr(a_addr2), .b_addr(b_addr2),
    .mac_en(mac_en2), .mac_first(mac_first2), .c_we(c_we2), .c_addr(c_addr2),
    .busy(busy2), .done(done2)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected per-cycle timeline, indexed by cycle number after start is sampled.
  bit hp[MAXC];
  bit e_rd[MAXC], e_mac[MAXC], e_first[MAXC], e_we[MAXC], e_busy[MAXC], e_done[MAXC];
  int e_a[MAXC], e_b[MAXC], e_wa[MAXC], e_caddr[MAXC];
  int last_cyc;
  int cur_caddr;

  int mem_a[NN], mem_b[NN], cmem[NN];
  int acc, pa, pb;
  logic [7:0] rd_log[$];

  task automatic build_model(input int caddr0);
    int t, r, i, j, k, ca;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_mac[c] = 0; e_first[c] = 0; e_we[c] = 0;
      e_busy[c] = 0; e_done[c] = 0; e_a[c] = 0; e_b[c] = 0; e_wa[c] = 0;
    end
    t = 1;
    r = 0;
    while (r < NNN) begin
      i = r / NN;
      j = (r / N) % N;
      k = r % N;
      e_busy[t] = 1;
      e_a[t]    = i * N + k;
      e_b[t]    = k * N + j;
      if (!hp[t]) begin
        e_rd[t]        = 1;
        e_mac[t + 1]   = 1;
        e_first[t + 1] = (k == 0);
        if (k == N - 1) begin
          e_we[t + 2] = 1;
          e_wa[t + 2] = i * N + j;
        end
        r++;
      end
      t++;
    end
    e_busy[t]     = 1;
    e_busy[t + 1] = 1;
    e_done[t + 2] = 1;
    last_cyc      = t + 3;
    ca = caddr0;
    for (int c = 0; c < MAXC; c++) begin
      if (e_we[c]) ca = e_wa[c];
      e_caddr[c] = ca;
    end
  endtask

  function automatic logic [31:0] pack_dut();
    return {14'b0, rd_en, a_addr, b_addr, mac_en, mac_first, c_we, c_addr, busy, done};
  endfunction

  function automatic logic [31:0] pack_exp(input int t);
    return {14'b0, e_rd[t], AW'(e_a[t]), AW'(e_b[t]), e_mac[t], e_first[t], e_we[t],
            AW'(e_caddr[t]), e_busy[t], e_done[t]};
  endfunction

  function automatic logic [31:0] pack_dut2();
    return {20'b0, rd_en2, a_addr2, b_addr2, mac_en2, mac_first2, c_we2, c_addr2, busy2, done2};
  endfunction

  // One full run: hold window [hs, hs+hl) plus random holds at pct percent.
  task automatic run_scenario(input string tag, input int hs, input int hl, input int pct,
                              output int first_we, output int done_cyc, output int nreads);
    int holds, mac_cnt, first_cnt, we_cnt, s;
    holds = 0;
    for (int c = 0; c < MAXC; c++) begin
      hp[c] = ((c >= hs) && (c < hs + hl)) || ($urandom_range(99) < pct);
      if (hp[c]) holds++;
      if (holds > 80) hp[c] = 0;
    end
    build_model(cur_caddr);
    for (int x = 0; x < NN; x++) cmem[x] = -1;
    acc = 0; pa = 0; pb = 0;
    mac_cnt = 0; first_cnt = 0; we_cnt = 0;
    first_we = -1; done_cyc = -1; nreads = 0;
    rd_log.delete();

    @(negedge clock);
    start = 1'b1;
    hold  = 1'($urandom);
    for (int t = 1; t <= last_cyc; t++) begin
      @(negedge clock);
      start = 1'b0;
      hold  = hp[t];
      #1;
      check($sformatf("%s cyc%0d", tag, t), pack_dut(), pack_exp(t));
      if (c_we) begin
        cmem[c_addr] = acc;
        we_cnt++;
        if (first_we < 0) first_we = t;
      end
      if (mac_en) begin
        mac_cnt++;
        if (mac_first) begin
          first_cnt++;
          acc = pa * pb;
        end else begin
          acc = acc + pa * pb;
        end
      end
      if (rd_en) begin
        pa = mem_a[a_addr];
        pb = mem_b[b_addr];
        nreads++;
        rd_log.push_back({a_addr, b_addr});
      end
      if (done) done_cyc = t;
    end

    check({tag, " mac_en count"}, mac_cnt, NNN);
    check({tag, " mac_first count"}, first_cnt, NN);
    check({tag, " c_we count"}, we_cnt, NN);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += mem_a[i * N + k] * mem_b[k * N + j];
        check($sformatf("%s C[%0d][%0d]", tag, i, j), cmem[i * N + j], s);
      end
    end
    cur_caddr = NN - 1;
  endtask

  typedef struct {
    int hs;
    int hl;
    int exp_first_we;
    int exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fw, dc, nr, d1, d2, n2, d2n;
    int wq_t[$];
    int wq_a[$];

    vecs[0] = '{hs: 0,  hl: 0, exp_first_we: 6, exp_done: 67};
    vecs[1] = '{hs: 3,  hl: 3, exp_first_we: 9, exp_done: 70};
    vecs[2] = '{hs: 1,  hl: 1, exp_first_we: 7, exp_done: 68};
    vecs[3] = '{hs: 4,  hl: 1, exp_first_we: 7, exp_done: 68};
    vecs[4] = '{hs: 64, hl: 2, exp_first_we: 6, exp_done: 69};

    reset = 1'b1; start = 1'b0; hold = 1'b0;
    reset2 = 1'b1; start2 = 1'b0; hold2 = 1'b0;
    cur_caddr = 0;
    repeat (2) @(negedge clock);
    #1;
    check("reset state", pack_dut(), 32'h0);
    check("reset state n2", pack_dut2(), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    reset2 = 1'b0;

    for (int x = 0; x < NN; x++) begin
      mem_a[x] = $urandom_range(255);
      mem_b[x] = $urandom_range(255);
    end
    for (int v = 0; v < 5; v++) begin
      run_scenario($sformatf("vec%0d", v), vecs[v].hs, vecs[v].hl, 0, fw, dc, nr);
      check($sformatf("vec%0d first c_we", v), fw, vecs[v].exp_first_we);
      check($sformatf("vec%0d done cycle", v), dc, vecs[v].exp_done);
      check($sformatf("vec%0d reads", v), nr, NNN);
      if (v == 0) begin
        check("read1 addr", rd_log[0], 8'h00);
        check("read2 addr", rd_log[1], 8'h14);
        check("read5 addr", rd_log[4], 8'h01);
      end
    end

    for (int x = 0; x < NN; x++) begin
      mem_a[x] = ((x / N) == (x % N)) ? 1 : 0;
      mem_b[x] = x + 1;
    end
    run_scenario("ident", 0, 0, 0, fw, dc, nr);
    for (int x = 0; x < NN; x++) check($sformatf("ident C==B [%0d]", x), cmem[x], x + 1);

    for (int r = 0; r < 4; r++) begin
      for (int x = 0; x < NN; x++) begin
        mem_a[x] = $urandom_range(255);
        mem_b[x] = $urandom_range(255);
      end
      run_scenario($sformatf("rand%0d", r), 0, 0, 30, fw, dc, nr);
      check($sformatf("rand%0d reads", r), nr, NNN);
    end

    // Reset in cycle 20 of a run: everything quiet from cycle 21, then a clean rerun.
    @(negedge clock);
    start = 1'b1;
    for (int t = 1; t <= 90; t++) begin
      @(negedge clock);
      start = 1'b0;
      reset = (t == 20);
      hold  = 1'($urandom);
      #1;
      if (t >= 21) check($sformatf("post-reset quiet cyc%0d", t), pack_dut(), 32'h0);
    end
    hold = 1'b0;
    cur_caddr = 0;
    run_scenario("after_reset", 0, 0, 0, fw, dc, nr);
    check("after_reset reads", nr, NNN);
    check("after_reset done", dc, 67);

    // Reset and start together: reset wins.
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      check($sformatf("reset+start idle %0d", t), {busy, rd_en, done}, 3'b000);
      @(negedge clock);
    end

    // start held high: back-to-back runs with one IDLE cycle between.
    start = 1'b1;
    hold  = 1'b0;
    d1 = -1;
    d2 = -1;
    for (int t = 1; t <= 300 && d2 < 0; t++) begin
      @(negedge clock);
      #1;
      if (d1 > 0 && t == d1 + 1) check("b2b idle gap", {busy, rd_en}, 2'b00);
      if (d1 > 0 && t == d1 + 2) check("b2b restart", {busy, rd_en}, 2'b11);
      if (done) begin
        if (d1 < 0) d1 = t;
        else d2 = t;
      end
    end
    check("b2b first done", d1, 67);
    check("b2b done spacing", d2 - d1, 68);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("b2b stop idle", {busy, rd_en}, 2'b00);

    // start pulses in RUN and in DONE are not queued.
    @(negedge clock);
    start = 1'b1;
    for (int t = 1; t <= 72; t++) begin
      @(negedge clock);
      start = (t == 10) || (t == 67);
      #1;
      if (t == 67) check("noqueue done", done, 1'b1);
      if (t >= 68) check($sformatf("noqueue idle cyc%0d", t), {busy, rd_en, done}, 3'b000);
    end
    start = 1'b0;

    // N=2, AW=2 corner.
    @(negedge clock);
    start2 = 1'b1;
    n2 = 0;
    d2n = -1;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clock);
      start2 = 1'b0;
      #1;
      if (rd_en2) n2++;
      if (c_we2) begin
        wq_t.push_back(t);
        wq_a.push_back(int'(c_addr2));
      end
      if (done2) d2n = t;
    end
    check("n2 reads", n2, 8);
    check("n2 c_we count", wq_t.size(), 4);
    for (int p = 0; p < wq_t.size(); p++) begin
      check($sformatf("n2 c_we%0d cycle", p), wq_t[p], 4 + 2 * p);
      check($sformatf("n2 c_we%0d addr", p), wq_a[p], p);
    end
    check("n2 done cycle", d2n, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
